// File: rtl/video_timing_param_if.sv
// Control and timing-output bundle for the raster timing generator.
// The generator sits on the slave side; a sink or controller uses the master side.
interface video_timing_param_if #(
    parameter int CNT_W = 12
);
    logic             enable;
    logic             cfg_we;
    logic [2:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_data;
    logic             hsync;
    logic             vsync;
    logic             data_en;
    logic             hblank;
    logic             vblank;
    logic             line_start;
    logic             frame_start;
    logic [CNT_W-1:0] xpos;
    logic [CNT_W-1:0] ypos;

    modport master (
        output enable, cfg_we, cfg_sel, cfg_data,
        input  hsync, vsync, data_en, hblank, vblank, line_start, frame_start, xpos, ypos
    );

    modport slave (
        input  enable, cfg_we, cfg_sel, cfg_data,
        output hsync, vsync, data_en, hblank, vblank, line_start, frame_start, xpos, ypos
    );
endinterface

// File: rtl/video_timing_param.sv
// Parameterised raster timing generator with double-buffered runtime configuration.
// Live timing only changes at a frame wrap or while idle, so a frame is never torn.
module video_timing_param #(
    parameter int CNT_W     = 12,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 64,
    parameter int H_BP      = 80,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 16,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    video_timing_param_if.slave vif
);
    localparam int TW = CNT_W + 1;
    localparam int SW = CNT_W + 2;
    localparam logic [SW-1:0] MAX_TOTAL = {2'b01, {CNT_W{1'b0}}};

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    function automatic cnt_t field_default(input logic [2:0] idx);
        case (idx)
            3'd0:    return cnt_t'(H_ACTIVE);
            3'd1:    return cnt_t'(H_FP);
            3'd2:    return cnt_t'(H_SYNC);
            3'd3:    return cnt_t'(H_BP);
            3'd4:    return cnt_t'(V_ACTIVE);
            3'd5:    return cnt_t'(V_FP);
            3'd6:    return cnt_t'(V_SYNC);
            default: return cnt_t'(V_BP);
        endcase
    endfunction

    state_t r_state;
    cnt_t   r_h;
    cnt_t   r_v;
    cnt_t   r_pend [8];
    cnt_t   r_live [8];
    logic   r_hsync;
    logic   r_vsync;
    logic   r_de;
    logic   r_hblank;
    logic   r_vblank;
    logic   r_line;
    logic   r_frame;

    cnt_t          w_pend_nxt [8];
    logic [SW-1:0] w_h_sum;
    logic [SW-1:0] w_v_sum;
    logic          w_pend_ok;
    logic          w_commit;
    logic [TW-1:0] w_htot;
    logic [TW-1:0] w_vtot;
    logic [TW-1:0] w_hs_lo;
    logic [TW-1:0] w_hs_hi;
    logic [TW-1:0] w_vs_lo;
    logic [TW-1:0] w_vs_hi;
    logic [TW-1:0] w_hx;
    logic [TW-1:0] w_vx;
    cnt_t          w_hlast;
    cnt_t          w_vlast;
    cnt_t          w_h_nxt;
    cnt_t          w_v_nxt;
    logic          w_run_nxt;
    logic          w_h_act;
    logic          w_v_act;
    logic          w_hs;
    logic          w_vs;

    // A write in the commit cycle is folded in so it takes effect at that same wrap
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_pend_nxt[i] = r_pend[i];
        end
        if (vif.cfg_we && (vif.cfg_data != '0)) begin
            w_pend_nxt[vif.cfg_sel] = vif.cfg_data;
        end
    end

    // Two guard bits keep the sum exact so oversize sets are caught rather than wrapped
    assign w_h_sum   = SW'(w_pend_nxt[0]) + SW'(w_pend_nxt[1]) + SW'(w_pend_nxt[2]) + SW'(w_pend_nxt[3]);
    assign w_v_sum   = SW'(w_pend_nxt[4]) + SW'(w_pend_nxt[5]) + SW'(w_pend_nxt[6]) + SW'(w_pend_nxt[7]);
    assign w_pend_ok = (w_h_sum <= MAX_TOTAL) && (w_v_sum <= MAX_TOTAL);

    assign w_htot  = TW'(r_live[0]) + TW'(r_live[1]) + TW'(r_live[2]) + TW'(r_live[3]);
    assign w_vtot  = TW'(r_live[4]) + TW'(r_live[5]) + TW'(r_live[6]) + TW'(r_live[7]);
    assign w_hlast = cnt_t'(w_htot - TW'(1));
    assign w_vlast = cnt_t'(w_vtot - TW'(1));
    assign w_hs_lo = TW'(r_live[0]) + TW'(r_live[1]);
    assign w_hs_hi = w_hs_lo + TW'(r_live[2]);
    assign w_vs_lo = TW'(r_live[4]) + TW'(r_live[5]);
    assign w_vs_hi = w_vs_lo + TW'(r_live[6]);

    assign w_commit = (r_state == ST_IDLE) || ((r_h == w_hlast) && (r_v == w_vlast));

    always_comb begin
        w_run_nxt = vif.enable;
        w_h_nxt   = '0;
        w_v_nxt   = '0;
        if (vif.enable && (r_state == ST_RUN)) begin
            if (r_h == w_hlast) begin
                w_v_nxt = (r_v == w_vlast) ? '0 : r_v + cnt_t'(1);
            end else begin
                w_h_nxt = r_h + cnt_t'(1);
                w_v_nxt = r_v;
            end
        end
    end

    // Decode against the upcoming position so every flag lines up with xpos/ypos
    assign w_hx    = {1'b0, w_h_nxt};
    assign w_vx    = {1'b0, w_v_nxt};
    assign w_h_act = w_hx < TW'(r_live[0]);
    assign w_v_act = w_vx < TW'(r_live[4]);
    assign w_hs    = (w_hx >= w_hs_lo) && (w_hx < w_hs_hi);
    assign w_vs    = (w_vx >= w_vs_lo) && (w_vx < w_vs_hi);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                r_pend[i] <= field_default(3'(i));
                r_live[i] <= field_default(3'(i));
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_pend[i] <= w_pend_nxt[i];
            end
            if (w_commit && w_pend_ok) begin
                for (int i = 0; i < 8; i++) begin
                    r_live[i] <= w_pend_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_h      <= '0;
            r_v      <= '0;
            r_hsync  <= ~HSYNC_POL;
            r_vsync  <= ~VSYNC_POL;
            r_de     <= 1'b0;
            r_hblank <= 1'b1;
            r_vblank <= 1'b1;
            r_line   <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_state  <= w_run_nxt ? ST_RUN : ST_IDLE;
            r_h      <= w_h_nxt;
            r_v      <= w_v_nxt;
            r_hsync  <= (w_run_nxt && w_hs) ? HSYNC_POL : ~HSYNC_POL;
            r_vsync  <= (w_run_nxt && w_vs) ? VSYNC_POL : ~VSYNC_POL;
            r_de     <= w_run_nxt && w_h_act && w_v_act;
            r_hblank <= !(w_run_nxt && w_h_act);
            r_vblank <= !(w_run_nxt && w_v_act);
            r_line   <= w_run_nxt && (w_h_nxt == '0);
            r_frame  <= w_run_nxt && (w_h_nxt == '0) && (w_v_nxt == '0);
        end
    end

    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.data_en     = r_de;
    assign vif.hblank      = r_hblank;
    assign vif.vblank      = r_vblank;
    assign vif.line_start  = r_line;
    assign vif.frame_start = r_frame;
    assign vif.xpos        = r_h;
    assign vif.ypos        = r_v;
endmodule

// File: tb/tb_video_timing_param.sv
// Directed bench for video_timing_param on a 16x8 raster (H 4/2/2/8, V 2/1/1/4).
// Two instances differ only in hsync polarity; a small position model supplies expectations.
module tb_video_timing_param;
    logic clk;
    logic resetn;

    video_timing_param_if #(.CNT_W(12)) va ();
    video_timing_param_if #(.CNT_W(12)) vb ();

    video_timing_param #(
        .CNT_W(12), .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(8),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(4), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_a (
        .clk(clk), .resetn(resetn), .vif(va.slave)
    );

    video_timing_param #(
        .CNT_W(12), .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(8),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(4), .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .resetn(resetn), .vif(vb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mh, mv, m_ha, m_ha_pend, m_htot;
    bit m_run;
    bit chkb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs for the modelled position; H porch/sync/bp are fixed at 2/2/8
    task automatic check_model();
        int  hs_lo;
        bit  e_hs, e_vs, e_de, e_hb, e_vb, e_ls, e_fs;
        hs_lo = m_ha + 2;
        e_hs  = m_run && (mh >= hs_lo) && (mh < hs_lo + 2);
        e_vs  = m_run && (mv == 3);
        e_de  = m_run && (mh < m_ha) && (mv < 2);
        e_hb  = !(m_run && (mh < m_ha));
        e_vb  = !(m_run && (mv < 2));
        e_ls  = m_run && (mh == 0);
        e_fs  = e_ls && (mv == 0);
        chk("xpos", 32'(va.xpos), m_run ? 32'(mh) : 32'd0);
        chk("ypos", 32'(va.ypos), m_run ? 32'(mv) : 32'd0);
        chk("hsync", 32'(va.hsync), 32'(e_hs));
        chk("vsync", 32'(va.vsync), 32'(e_vs));
        chk("data_en", 32'(va.data_en), 32'(e_de));
        chk("hblank", 32'(va.hblank), 32'(e_hb));
        chk("vblank", 32'(va.vblank), 32'(e_vb));
        chk("line_start", 32'(va.line_start), 32'(e_ls));
        chk("frame_start", 32'(va.frame_start), 32'(e_fs));
        if (chkb) chk("hsync_neg", 32'(vb.hsync), 32'(!e_hs));
    endtask

    task automatic model_step();
        bit commit;
        commit = !m_run || ((mh == m_htot - 1) && (mv == 7));
        if (!va.enable) begin
            m_run = 0; mh = 0; mv = 0;
        end else if (!m_run) begin
            m_run = 1; mh = 0; mv = 0;
        end else if (mh == m_htot - 1) begin
            mh = 0;
            mv = (mv == 7) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        if (commit) begin
            m_ha   = m_ha_pend;
            m_htot = m_ha + 12;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_step();
            check_model();
        end
    endtask

    task automatic wr(input int sel, input int data);
        va.cfg_we   = 1'b1;
        va.cfg_sel  = 3'(sel);
        va.cfg_data = 12'(data);
        if ((data != 0) && (sel == 0)) m_ha_pend = data;
        run(1);
        va.cfg_we = 1'b0;
    endtask

    task automatic set_en(input logic e);
        va.enable = e;
        vb.enable = e;
    endtask

    task automatic run_to_last();
        int n;
        n = 0;
        while (!(m_run && (mh == m_htot - 1) && (mv == 7)) && (n < 400)) begin
            run(1);
            n++;
        end
        chk("reach_frame_end", 32'(n < 400), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        set_en(1'b0);
        va.cfg_we = 1'b0; va.cfg_sel = 3'd0; va.cfg_data = '0;
        vb.cfg_we = 1'b0; vb.cfg_sel = 3'd0; vb.cfg_data = '0;
        m_run = 0; mh = 0; mv = 0; m_ha = 4; m_ha_pend = 4; m_htot = 16;
        chkb = 1;

        // Held in reset: idle outputs, both polarities
        repeat (2) @(posedge clk);
        #1;
        check_model();

        // First frame from enable: frame_start on the first enabled cycle, 16x8 raster
        resetn = 1'b1;
        set_en(1'b1);
        run(128);
        chkb = 0;
        run(1);
        chk("frame2_start", 32'(va.frame_start), 32'd1);

        // Mid-frame write: current frame keeps 16-clk lines, next uses 18
        run(19);
        wr(0, 6);
        run_to_last();
        run(1);
        chk("ha6_applied", 32'(m_ha), 32'd6);
        run(40);

        // Write landing exactly on the wrap cycle applies at that wrap
        run_to_last();
        wr(0, 4);
        run(40);

        // Zero value is ignored: next frame keeps 16-clk lines
        wr(0, 0);
        run_to_last();
        run(40);

        // Drop enable on line 3, sit idle, then restart
        begin
            int n;
            n = 0;
            while ((mv != 3) && (n < 400)) begin
                run(1);
                n++;
            end
            chk("reach_line3", 32'(n < 400), 32'd1);
        end
        run(5);
        set_en(1'b0);
        run(1);
        chk("idle_xpos", 32'(va.xpos), 32'd0);
        chk("idle_hblank", 32'(va.hblank), 32'd1);
        // An oversize H total must be rejected, leaving 16-clk lines
        wr(3, 4095);
        run(2);
        set_en(1'b1);
        run(1);
        chk("restart_frame_start", 32'(va.frame_start), 32'd1);
        run(40);

        // Asynchronous reset between edges, with a pending change that must be discarded
        wr(0, 6);
        run(5);
        #3;
        resetn = 1'b0;
        #1;
        m_run = 0; mh = 0; mv = 0; m_ha = 4; m_ha_pend = 4; m_htot = 16;
        chkb = 1;
        check_model();
        @(posedge clk);
        #1;
        check_model();
        resetn = 1'b1;
        run(1);
        chk("post_reset_frame_start", 32'(va.frame_start), 32'd1);
        run(140);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
